// File: rtl/pmem_arbiter.sv
// Two-way arbiter sharing one physical-memory line port between the I-cache and D-cache miss paths.
// One transaction in flight; round-robin on contention; address/data/op latched at grant.
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic i_req, d_req, grant_i;

  assign i_req   = i_pmem_read;
  assign d_req   = d_pmem_read | d_pmem_write;
  // I wins when alone, or on contention when D had the previous grant
  assign grant_i = i_req & (~d_req | last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = I_BUSY;
          last_d_d = 1'b0;
          addr_d   = i_pmem_address;
          wr_d     = 1'b0;
        end else if (d_req) begin
          state_d  = D_BUSY;
          last_d_d = 1'b1;
          addr_d   = d_pmem_address;
          wdata_d  = d_pmem_wdata;
          wr_d     = d_pmem_write;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes depend only on registered state, so they are glitch-free toward memory
  always_comb begin
    pmem_read   = (state_q == I_BUSY) | ((state_q == D_BUSY) & ~wr_q);
    pmem_write  = (state_q == D_BUSY) & wr_q;
    i_pmem_resp = pmem_resp & (state_q == I_BUSY);
    d_pmem_resp = pmem_resp & (state_q == D_BUSY);
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: transaction-level reference model, directed scenarios, then randomized traffic.
module tb_pmem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  pmem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port (0 none, 1 I, 2 D), cycles before arbitration reopens
  int            m_owner;
  int            m_wait;
  bit            m_prev_d;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            grants[$];

  bit auto_req, auto_mem;
  bit i_fin, d_fin;
  int mem_cnt;

  function automatic logic [LW-1:0] r256();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_prev_d = 1'b1; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0;
    grants.delete();
  endtask

  task automatic model_step();
    bit ir, dr;
    if (!rst) return;
    if (m_owner != 0) begin
      if (pmem_resp) begin
        if (m_owner == 1) i_fin = 1'b1; else d_fin = 1'b1;
        m_owner = 0;
        m_wait  = 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      ir = i_pmem_read;
      dr = d_pmem_read | d_pmem_write;
      if (ir && (!dr || m_prev_d)) begin
        m_owner = 1; m_addr = i_pmem_address; m_wr = 1'b0; m_prev_d = 1'b0;
        grants.push_back(1);
        mem_cnt = $urandom_range(0, 3);
      end else if (dr) begin
        m_owner = 2; m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
        m_wr = d_pmem_write; m_prev_d = 1'b1;
        grants.push_back(2);
        mem_cnt = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic drive_auto();
    if (auto_req) begin
      if (i_fin) begin i_fin = 1'b0; i_pmem_read = 1'b0; end
      if (!i_pmem_read && ($urandom % 3 == 0)) begin
        i_pmem_read = 1'b1; i_pmem_address = $urandom;
      end
      if (d_fin) begin d_fin = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      if (!d_pmem_read && !d_pmem_write && ($urandom % 3 == 0)) begin
        case ($urandom % 3)
          0:       begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
          1:       begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
          default: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
        endcase
        d_pmem_address = $urandom;
      end
      d_pmem_wdata = r256();
    end
    if (auto_mem) begin
      pmem_rdata = r256();
      if (m_owner != 0) begin
        if (mem_cnt == 0) pmem_resp = 1'b1;
        else begin mem_cnt--; pmem_resp = 1'b0; end
      end else begin
        pmem_resp = ($urandom % 6 == 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive_auto();
  endtask

  task automatic settle();
    @(negedge clk);
    chk("pmem_read",    LW'(pmem_read),    LW'((m_owner == 1) || (m_owner == 2 && !m_wr)));
    chk("pmem_write",   LW'(pmem_write),   LW'(m_owner == 2 && m_wr));
    chk("pmem_address", LW'(pmem_address), LW'(m_addr));
    chk("pmem_wdata",   pmem_wdata,        m_wdata);
    chk("i_pmem_resp",  LW'(i_pmem_resp),  LW'(pmem_resp && m_owner == 1));
    chk("d_pmem_resp",  LW'(d_pmem_resp),  LW'(pmem_resp && m_owner == 2));
    chk("i_pmem_rdata", i_pmem_rdata,      pmem_rdata);
    chk("d_pmem_rdata", d_pmem_rdata,      pmem_rdata);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    settle();
    tick();
    rst = 1'b1;
    settle();
  endtask

  initial begin
    bit strobe, prev, seen;
    int lowrun;
    rst = 1'b0;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    auto_req = 1'b0; auto_mem = 1'b0; i_fin = 1'b0; d_fin = 1'b0; mem_cnt = 0;
    model_reset();

    settle();
    chk("reset_pmem_read",  LW'(pmem_read),    '0);
    chk("reset_pmem_write", LW'(pmem_write),   '0);
    chk("reset_address",    LW'(pmem_address), '0);
    chk("reset_wdata",      pmem_wdata,        '0);
    do_reset();

    // I-cache read alone
    tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000; settle();
    chk("t1_strobe_at_N", LW'(pmem_read), '0);
    tick(); settle();
    chk("t1_read_N1", LW'(pmem_read), LW'(1));
    chk("t1_addr",    LW'(pmem_address), LW'(32'h0000_1000));
    tick(); pmem_rdata = {8{32'hA5A5_A5A5}}; pmem_resp = 1'b1; settle();
    chk("t1_i_resp", LW'(i_pmem_resp), LW'(1));
    chk("t1_rdata",  i_pmem_rdata, {8{32'hA5A5_A5A5}});
    chk("t1_d_resp", LW'(d_pmem_resp), '0);
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; settle();
    chk("t1_done_low", LW'(pmem_read), '0);
    tick(); settle();

    // D-cache write-back alone, wdata changes while busy
    tick(); d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2040;
    d_pmem_wdata = {8{32'hDEAD_BEEF}}; settle();
    tick(); d_pmem_wdata = {8{32'h1234_5678}}; settle();
    chk("t2_write", LW'(pmem_write), LW'(1));
    chk("t2_read",  LW'(pmem_read), '0);
    chk("t2_addr",  LW'(pmem_address), LW'(32'h0000_2040));
    chk("t2_wdata", pmem_wdata, {8{32'hDEAD_BEEF}});
    tick(); settle();
    chk("t2_wdata_hold", pmem_wdata, {8{32'hDEAD_BEEF}});
    tick(); pmem_resp = 1'b1; settle();
    chk("t2_d_resp", LW'(d_pmem_resp), LW'(1));
    chk("t2_i_resp", LW'(i_pmem_resp), '0);
    tick(); pmem_resp = 1'b0; d_pmem_write = 1'b0; settle();
    chk("t2_d_resp_gone", LW'(d_pmem_resp), '0);
    tick(); settle();

    // read+write together is a write; stray resp in idle is ignored
    tick(); d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_3000; settle();
    tick(); settle();
    chk("t5_write", LW'(pmem_write), LW'(1));
    chk("t5_read",  LW'(pmem_read), '0);
    tick(); pmem_resp = 1'b1; settle();
    tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; settle();
    tick(); settle();
    tick(); pmem_resp = 1'b1; settle();
    chk("t5_stray_i", LW'(i_pmem_resp), '0);
    chk("t5_stray_d", LW'(d_pmem_resp), '0);
    tick(); pmem_resp = 1'b0; settle();
    chk("t5_stray_idle", LW'(pmem_read | pmem_write), '0);

    // Contention from reset: alternating grants with a 2-cycle strobe gap
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    auto_mem = 1'b1;
    prev = 1'b0; seen = 1'b0; lowrun = 0;
    for (int c = 0; c < 80 && grants.size() < 5; c++) begin
      tick(); settle();
      strobe = pmem_read | pmem_write;
      if (strobe && !prev) begin
        if (seen) chk("t3_gap", LW'(lowrun), LW'(2));
        seen = 1'b1;
      end
      if (strobe) lowrun = 0; else lowrun++;
      prev = strobe;
    end
    chk("t3_grant_count", LW'(grants.size() >= 4), LW'(1));
    if (grants.size() >= 4) begin
      chk("t3_grant0", LW'(grants[0]), LW'(1));
      chk("t3_grant1", LW'(grants[1]), LW'(2));
      chk("t3_grant2", LW'(grants[2]), LW'(1));
      chk("t3_grant3", LW'(grants[3]), LW'(2));
    end

    // Async reset in the middle of a D write
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_5000;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
        tick(); settle();
        if (m_owner == 2 && m_wr) hit = 1'b1;
      end
      chk("t4_reached_dbusy", LW'(hit), LW'(1));
    end
    auto_mem = 1'b0; pmem_resp = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t4_async_write", LW'(pmem_write), '0);
    chk("t4_async_read",  LW'(pmem_read), '0);
    chk("t4_async_dresp", LW'(d_pmem_resp), '0);
    chk("t4_async_addr",  LW'(pmem_address), '0);
    model_reset();
    i_fin = 1'b0; d_fin = 1'b0;
    d_pmem_write = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_4400;
    tick(); rst = 1'b1; settle();
    tick(); settle();
    chk("t4_i_granted", LW'(pmem_read), LW'(1));
    chk("t4_i_addr",    LW'(pmem_address), LW'(32'h0000_4400));

    // Randomized traffic against the model
    auto_mem = 1'b1;
    auto_req = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick(); settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
